// File: rtl/vortex_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vortex_mem_responder_pkg
//  Description : Shared types and constants for the Vortex line-to-word
//                memory responder. Holds the FSM state encoding and the
//                beats-per-line figure for the default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package vortex_mem_responder_pkg;

  // FSM state encoding, kept as explicit-width constants so the encoding is
  // stable for any tool or waveform viewer that decodes it numerically.
  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t WRITE = 2'd1;
  localparam state_t READ  = 2'd2;
  localparam state_t RESP  = 2'd3;

  // Number of downstream words needed to move one Vortex line.
  function automatic int beats_per_line(input int line_width, input int word_width);
    return line_width / word_width;
  endfunction

  localparam int DEF_MEM_DATA_WIDTH = 512;
  localparam int DEF_WORD_WIDTH     = 32;
  localparam int BEATS_PER_LINE     = beats_per_line(DEF_MEM_DATA_WIDTH, DEF_WORD_WIDTH);

endpackage : vortex_mem_responder_pkg
`default_nettype wire

// File: rtl/vortex_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : vortex_mem_responder
//  Description : Serves Vortex line-sized memory requests over a narrow
//                word-wide downstream bus. A write line is split into one
//                bus write per word (words with an all-zero strobe are skipped
//                silently); a read line is gathered word by word into a line
//                buffer and returned as a single response.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, reset                     clock, synchronous active-high reset
//    mem_req_valid/rw/byteen/addr/
//    mem_req_data/tag               Vortex request (rw=1 means write)
//    mem_req_ready                  request accept, high only when idle
//    mem_rsp_valid/data/tag         read response, held until mem_rsp_ready
//    mem_rsp_ready                  Vortex response accept
//    bus_ren/wen/addr/wdata/strobe  downstream word master
//    bus_rdata/request_stall/error  downstream word response
//    busy                           a transaction is in flight
//    err_sticky                     a bus error was seen since reset
// ============================================================================
module vortex_mem_responder
  import vortex_mem_responder_pkg::*;
#(
  parameter int          MEM_DATA_WIDTH = 512,
  parameter int          MEM_ADDR_WIDTH = 26,
  parameter int          MEM_TAG_WIDTH  = 56,
  parameter int          WORD_WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic                          mem_req_valid,
  input  logic                          mem_req_rw,
  input  logic [MEM_DATA_WIDTH/8-1:0]   mem_req_byteen,
  input  logic [MEM_ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic [MEM_DATA_WIDTH-1:0]     mem_req_data,
  input  logic [MEM_TAG_WIDTH-1:0]      mem_req_tag,
  output logic                          mem_req_ready,

  output logic                          mem_rsp_valid,
  output logic [MEM_DATA_WIDTH-1:0]     mem_rsp_data,
  output logic [MEM_TAG_WIDTH-1:0]      mem_rsp_tag,
  input  logic                          mem_rsp_ready,

  output logic                          bus_ren,
  output logic                          bus_wen,
  output logic [31:0]                   bus_addr,
  output logic [WORD_WIDTH-1:0]         bus_wdata,
  output logic [WORD_WIDTH/8-1:0]       bus_strobe,
  input  logic [WORD_WIDTH-1:0]         bus_rdata,
  input  logic                          bus_request_stall,
  input  logic                          bus_error,

  output logic                          busy,
  output logic                          err_sticky
);

  localparam int c_beats      = beats_per_line(MEM_DATA_WIDTH, WORD_WIDTH);
  localparam int c_beat_w     = $clog2(c_beats);
  localparam int c_strb_w     = WORD_WIDTH / 8;
  localparam int c_byteen_w   = MEM_DATA_WIDTH / 8;
  localparam int c_line_shift = $clog2(c_byteen_w);
  localparam int c_word_shift = $clog2(c_strb_w);

  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                      r_state;
  logic [c_beat_w-1:0]         r_beat;      // index of the beat on the bus
  logic [MEM_ADDR_WIDTH-1:0]   r_addr;
  logic [MEM_DATA_WIDTH-1:0]   r_data;
  logic [c_byteen_w-1:0]       r_byteen;
  logic [MEM_TAG_WIDTH-1:0]    r_tag;
  logic [WORD_WIDTH-1:0]       r_line [c_beats];
  logic                        r_err;

  logic                        r_bus_ren;
  logic                        r_bus_wen;
  logic [31:0]                 r_bus_addr;
  logic [WORD_WIDTH-1:0]       r_bus_wdata;
  logic [c_strb_w-1:0]         r_bus_strobe;

  // --------------------------------------------------------------------------
  // Beat sequencing
  // --------------------------------------------------------------------------
  logic                        w_accept;
  logic                        w_bus_active;
  logic                        w_beat_fire;
  logic                        w_beat_done;
  logic                        w_last;
  logic                        w_load;
  logic                        w_ld_is_write;
  logic [c_beat_w-1:0]         w_ld_idx;
  logic [MEM_ADDR_WIDTH-1:0]   w_src_addr;
  logic [MEM_DATA_WIDTH-1:0]   w_src_data;
  logic [c_byteen_w-1:0]       w_src_byteen;
  logic [WORD_WIDTH-1:0]       w_src_words [c_beats];
  logic [c_strb_w-1:0]         w_src_strbs [c_beats];
  logic [31:0]                 w_ld_addr;
  logic [WORD_WIDTH-1:0]       w_ld_word;
  logic [c_strb_w-1:0]         w_ld_strb;

  assign w_accept     = mem_req_valid && (r_state == IDLE);
  assign w_bus_active = r_bus_ren | r_bus_wen;
  assign w_beat_fire  = w_bus_active && !bus_request_stall;

  // A skipped write word has no bus activity, so it retires in one cycle
  // regardless of the stall input. A read beat always drives ren.
  assign w_beat_done  = ((r_state == WRITE) || (r_state == READ)) &&
                        (!w_bus_active || !bus_request_stall);
  assign w_last       = (r_beat == c_last_beat);

  // The bus registers are loaded one step ahead: on accept they take beat 0
  // straight from the request inputs, afterwards the next beat comes from the
  // latched request. This keeps every bus output a flop.
  assign w_load        = w_accept || (w_beat_done && !w_last);
  assign w_ld_idx      = w_accept ? '0 : r_beat + 1'b1;
  assign w_ld_is_write = w_accept ? mem_req_rw : (r_state == WRITE);
  assign w_src_addr    = w_accept ? mem_req_addr   : r_addr;
  assign w_src_data    = w_accept ? mem_req_data   : r_data;
  assign w_src_byteen  = w_accept ? mem_req_byteen : r_byteen;

  for (genvar g = 0; g < c_beats; g++) begin : g_word
    assign w_src_words[g] = w_src_data[g*WORD_WIDTH +: WORD_WIDTH];
    assign w_src_strbs[g] = w_src_byteen[g*c_strb_w +: c_strb_w];
    assign mem_rsp_data[g*WORD_WIDTH +: WORD_WIDTH] = r_line[g];
  end

  // 32-bit arithmetic: the downstream address wraps silently past 2^32.
  assign w_ld_addr = BASE_ADDR
                   + (32'(w_src_addr) << c_line_shift)
                   + (32'(w_ld_idx)   << c_word_shift);
  assign w_ld_word = w_src_words[w_ld_idx];
  assign w_ld_strb = w_ld_is_write ? w_src_strbs[w_ld_idx] : '1;

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_byteen     <= '0;
      r_tag        <= '0;
      r_err        <= 1'b0;
      r_bus_ren    <= 1'b0;
      r_bus_wen    <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_strobe <= '0;
      for (int i = 0; i < c_beats; i++) begin
        r_line[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_req_valid) begin
            r_addr   <= mem_req_addr;
            r_data   <= mem_req_data;
            r_byteen <= mem_req_byteen;
            r_tag    <= mem_req_tag;
            r_beat   <= '0;
            r_state  <= mem_req_rw ? WRITE : READ;
          end
        end
        WRITE, READ: begin
          if (w_beat_done) begin
            if (r_state == READ) begin
              r_line[r_beat] <= bus_rdata;
            end
            if (w_last) begin
              r_state   <= (r_state == WRITE) ? IDLE : RESP;
              r_bus_ren <= 1'b0;
              r_bus_wen <= 1'b0;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        RESP: begin
          if (mem_rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_load) begin
        r_bus_addr   <= w_ld_addr;
        r_bus_wdata  <= w_ld_is_write ? w_ld_word : '0;
        r_bus_strobe <= w_ld_strb;
        r_bus_ren    <= !w_ld_is_write;
        r_bus_wen    <= w_ld_is_write && (|w_ld_strb);
      end

      // Errors are recorded but never alter the transaction flow.
      if (w_beat_fire && bus_error) begin
        r_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_req_ready = (r_state == IDLE);
  assign mem_rsp_valid = (r_state == RESP);
  assign mem_rsp_tag   = r_tag;
  assign bus_ren       = r_bus_ren;
  assign bus_wen       = r_bus_wen;
  assign bus_addr      = r_bus_addr;
  assign bus_wdata     = r_bus_wdata;
  assign bus_strobe    = r_bus_strobe;
  assign busy          = (r_state != IDLE);
  assign err_sticky    = r_err;

endmodule : vortex_mem_responder
`default_nettype wire

// File: tb/tb_vortex_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vortex_mem_responder
//  Description : Scoreboard bench for vortex_mem_responder. Each request is
//                expanded by a transaction-level model into its expected bus
//                beats and (for reads) its expected response line; monitors
//                pop and compare as the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vortex_mem_responder;

  localparam int          DW   = 512;
  localparam int          AW   = 26;
  localparam int          TW   = 56;
  localparam int          BEW  = DW / 8;
  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } rsp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            mem_req_valid, mem_req_rw;
  logic [BEW-1:0]  mem_req_byteen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [TW-1:0]   mem_req_tag;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic [TW-1:0]   mem_rsp_tag;
  logic            mem_rsp_ready;
  logic            bus_ren, bus_wen;
  logic [31:0]     bus_addr, bus_wdata, bus_rdata;
  logic [3:0]      bus_strobe;
  logic            bus_request_stall, bus_error;
  logic            busy, err_sticky;

  always #5 clk = ~clk;

  vortex_mem_responder dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_strobe(bus_strobe), .bus_rdata(bus_rdata),
    .bus_request_stall(bus_request_stall), .bus_error(bus_error),
    .busy(busy), .err_sticky(err_sticky)
  );

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    hs_cyc = 0;
  beat_t exp_bus[$];
  rsp_t  exp_rsp[$];
  logic  err_exp = 1'b0;

  // Downstream slave controls
  logic        lin_mode = 1'b0;
  logic        stall_rand = 1'b0, err_rand = 1'b0, rsp_rand = 1'b0;
  logic        rsp_ready_val = 1'b1;
  int          stall_cnt = 0;
  logic [31:0] stall_addr = '0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event not expected / bound expired", nm);
  endtask

  // Memory contents seen by reads: either a simple per-word ramp or a hash.
  function automatic logic [31:0] rdata_fn(input logic lin, input logic [31:0] a);
    if (lin) return 32'h1000 + {28'd0, a[5:2]};
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  assign bus_rdata = rdata_fn(lin_mode, bus_addr);

  // Slave and response-ready drivers, updated just after each active edge.
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0 && bus_ren && bus_addr == stall_addr) begin
      bus_request_stall = 1'b1;
      stall_cnt--;
    end else begin
      bus_request_stall = stall_rand && ($urandom_range(0, 3) == 0);
    end
    bus_error = (err_en && bus_wen && bus_addr == err_addr) ||
                (err_rand && (bus_ren || bus_wen) && ($urandom_range(0, 15) == 0));
    mem_rsp_ready = rsp_rand ? ($urandom_range(0, 2) != 0) : rsp_ready_val;
  end

  // Monitor: compares bus beats and responses against the scoreboard.
  beat_t mon_act, mon_held, mon_exp;
  logic  mon_held_v = 1'b0;
  rsp_t  mon_r, mon_rheld;
  logic  mon_rheld_v = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      mon_held_v  = 1'b0;
      mon_rheld_v = 1'b0;
    end else begin
      mon_act.we   = bus_wen;
      mon_act.addr = bus_addr;
      mon_act.data = bus_wen ? bus_wdata : 32'd0;
      mon_act.strb = bus_strobe;
      if (bus_ren && bus_wen) fail_now("ren_wen_together");
      if (bus_ren || bus_wen) begin
        if (mon_held_v) chk("bus_hold_during_stall", mon_act, mon_held);
        if (bus_request_stall) begin
          mon_held_v = 1'b1;
          mon_held   = mon_act;
        end else begin
          mon_held_v = 1'b0;
          if (exp_bus.size() == 0) fail_now("unexpected_bus_beat");
          else begin
            mon_exp = exp_bus.pop_front();
            chk("bus_beat", mon_act, mon_exp);
          end
          if (bus_error) err_exp = 1'b1;
        end
      end else begin
        mon_held_v = 1'b0;
      end

      if (mem_rsp_valid) begin
        mon_r.data = mem_rsp_data;
        mon_r.tag  = mem_rsp_tag;
        if (mon_rheld_v) chk("rsp_stable", mon_r, mon_rheld);
        if (mem_rsp_ready) begin
          mon_rheld_v = 1'b0;
          hs_cyc      = cyc + 1;
          if (exp_rsp.size() == 0) fail_now("unexpected_rsp");
          else chk("rsp_line", mon_r, exp_rsp.pop_front());
        end else begin
          mon_rheld_v = 1'b1;
          mon_rheld   = mon_r;
        end
      end else begin
        mon_rheld_v = 1'b0;
      end
    end
  end

  // Transaction-level model + request driver. Returns the accept cycle.
  task automatic send(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BEW-1:0] be, input logic [TW-1:0] tag, output int acc);
    rsp_t        r;
    beat_t       b;
    logic [31:0] ba;
    r.data = '0;
    r.tag  = tag;
    for (int i = 0; i < 16; i++) begin
      ba = BASE + {a, 6'b0} + 32'(4 * i);
      if (rw) begin
        if (be[4*i +: 4] != 4'h0) begin
          b.we = 1'b1; b.addr = ba; b.data = d[32*i +: 32]; b.strb = be[4*i +: 4];
          exp_bus.push_back(b);
        end
      end else begin
        b.we = 1'b0; b.addr = ba; b.data = 32'd0; b.strb = 4'hF;
        exp_bus.push_back(b);
        r.data[32*i +: 32] = rdata_fn(lin_mode, ba);
      end
    end
    if (!rw) exp_rsp.push_back(r);

    mem_req_rw = rw; mem_req_addr = a; mem_req_data = d;
    mem_req_byteen = be; mem_req_tag = tag; mem_req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 400 && acc < 0; k++) begin
      @(negedge clk);
      if (mem_req_ready) begin
        @(posedge clk); #1;
        acc = cyc;
      end
    end
    mem_req_valid = 1'b0;
    if (acc < 0) fail_now("accept_timeout");
  endtask

  task automatic wait_rsp(input int acc, output int lat);
    lat = -1;
    for (int k = 0; k < 200 && lat < 0; k++) begin
      @(negedge clk);
      if (mem_rsp_valid) lat = cyc - acc;
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 800) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_idle"}, busy, 1'b0);
    chk({nm, "_beats_left"}, exp_bus.size(), 0);
    chk({nm, "_rsps_left"}, exp_rsp.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [BEW-1:0] rand_be();
    logic [BEW-1:0] be;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       be[4*i +: 4] = 4'h0;
        1:       be[4*i +: 4] = 4'hF;
        default: be[4*i +: 4] = 4'($urandom());
      endcase
    end
    return be;
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          acc, acc2, lat;
    logic        found;
    logic [AW-1:0] a;
    logic [31:0] tgt;

    reset = 1'b1;
    mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_byteen = '0;
    mem_req_addr = '0; mem_req_data = '0; mem_req_tag = '0;
    mem_rsp_ready = 1'b1; bus_request_stall = 1'b0; bus_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", mem_req_ready, 1'b1);
    chk("rst_rsp_valid", mem_rsp_valid, 1'b0);
    chk("rst_ren_wen", {bus_ren, bus_wen}, 2'b00);
    chk("rst_err", err_sticky, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_rsp_tag", mem_rsp_tag, '0);
    chk("rst_rsp_data", mem_rsp_data, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Plain read of line 1 with ramp data, no stalls
    lin_mode = 1'b1;
    send(1'b0, 26'h1, '0, '0, 56'hAB_CDEF_0123_4567, acc);
    wait_rsp(acc, lat);
    chk("read_latency", lat, 16);
    chk("read_word0", mem_rsp_data[31:0], 32'h1000);
    chk("read_word15", mem_rsp_data[511:480], 32'h100F);
    wait_idle("read1");
    lin_mode = 1'b0;

    // Sparse write: only the first two words carry strobes
    send(1'b1, 26'h2A5, rand_line(), 64'h0000_0000_0000_00F3, 56'h11, acc);
    wait_idle("write_sparse");

    // Read with a three-cycle stall on beat 5
    stall_addr = 32'h8000_0014;
    stall_cnt  = 3;
    send(1'b0, 26'h0, '0, '0, 56'h22, acc);
    wait_rsp(acc, lat);
    chk("stall_read_latency", lat, 19);
    chk("stall_cnt_used", stall_cnt, 0);
    wait_idle("read_stall");

    // Response back-pressure with a second request waiting
    rsp_ready_val = 1'b0;
    send(1'b0, 26'h3FF_FFFF, '0, '0, 56'h33, acc);
    wait_rsp(acc, lat);
    chk("wrap_read_latency", lat, 16);
    fork
      send(1'b0, 26'h155, '0, '0, 56'h44, acc2);
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("hold_rsp_valid", mem_rsp_valid, 1'b1);
          chk("hold_req_ready", mem_req_ready, 1'b0);
        end
        rsp_ready_val = 1'b1;
      end
    join
    chk("b2b_accept_cycle", acc2, hs_cyc + 1);
    wait_idle("backpressure");

    // Write with a bus error on beat 7
    chk("err_before", err_sticky, 1'b0);
    a = 26'h0C3;
    err_addr = BASE + {a, 6'b0} + 32'd28;
    err_en = 1'b1;
    send(1'b1, a, rand_line(), '1, 56'h55, acc);
    wait_idle("write_err");
    err_en = 1'b0;
    chk("err_set", err_sticky, 1'b1);
    send(1'b1, 26'h0C4, rand_line(), rand_be(), 56'h56, acc);
    wait_idle("write_after_err");
    chk("err_still_set", err_sticky, 1'b1);

    // Reset while beat 8 of a read is on the bus
    a = 26'h077;
    tgt = BASE + {a, 6'b0} + 32'd32;
    send(1'b0, a, '0, '0, 56'h66, acc);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (bus_ren && bus_addr == tgt) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!found) fail_now("beat8_not_seen");
    reset = 1'b1;
    @(posedge clk); #1;
    exp_bus.delete();
    exp_rsp.delete();
    err_exp = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_rsp_valid", mem_rsp_valid, 1'b0);
    chk("abort_ren", bus_ren, 1'b0);
    chk("abort_err", err_sticky, 1'b0);
    chk("abort_line", mem_rsp_data, '0);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", mem_rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    send(1'b0, a, '0, '0, 56'h67, acc);
    wait_rsp(acc, lat);
    chk("post_abort_latency", lat, 16);
    wait_idle("post_abort");

    // Randomised traffic with random stalls, errors and back-pressure
    stall_rand = 1'b1;
    err_rand   = 1'b1;
    rsp_rand   = 1'b1;
    for (int t = 0; t < 30; t++) begin
      send(1'($urandom_range(0, 1)), AW'($urandom()), rand_line(), rand_be(),
           {24'($urandom()), 32'($urandom())}, acc);
    end
    wait_idle("random");
    chk("err_sticky_model", err_sticky, err_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_vortex_mem_responder
`default_nettype wire
